// File: rtl/mat_mul_pkg.sv
// Shared types and sizing helpers for the sequential matrix multiplier.
package mat_mul_pkg;

   localparam int unsigned COUNTER_W = 32;

   typedef enum logic [1:0] {
      StIdle,
      StCompute,
      StDone
   } state_e;

   // Wide enough that a full COLS_A-term dot product never overflows.
   function automatic int unsigned acc_width(input int unsigned data_width,
                                             input int unsigned cols_a);
      return 2 * data_width + $clog2(cols_a) + 1;
   endfunction

   function automatic int unsigned elem_idx(input int unsigned row, input int unsigned col,
                                            input int unsigned cols);
      return row * cols + col;
   endfunction

endpackage

// File: rtl/mat_mul_mac.sv
// Registered multiply-accumulate plus reduction of the sum to OUT_WIDTH.
// MAT_MUL_SAT_EN selects saturation instead of truncation and adds the ovf_o flag.
module mat_mul_mac #(
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned ACC_W      = 18,
   parameter int unsigned OUT_WIDTH  = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  clr_i,
   input  logic                  en_i,
   input  logic                  first_i,
   input  logic [DATA_WIDTH-1:0] a_i,
   input  logic [DATA_WIDTH-1:0] b_i,
`ifdef MAT_MUL_SAT_EN
   output logic                  ovf_o,
`endif
   output logic [OUT_WIDTH-1:0]  acc_red_o
);

   localparam int unsigned EXT_W = (ACC_W > OUT_WIDTH) ? ACC_W : OUT_WIDTH;

   logic [ACC_W-1:0] acc_q, acc_d;
   logic [ACC_W-1:0] prod;

   function automatic logic [OUT_WIDTH-1:0] reduce(input logic [ACC_W-1:0] acc);
      logic [EXT_W-1:0] ext;
      ext = EXT_W'(acc);
`ifdef MAT_MUL_SAT_EN
      if (ext > EXT_W'({OUT_WIDTH{1'b1}})) begin
         return '1;
      end
`endif
      return ext[OUT_WIDTH-1:0];
   endfunction

   assign prod = ACC_W'(a_i) * ACC_W'(b_i);

   // The first term of a dot product loads rather than adds, so no idle clear cycle is needed.
   always_comb begin
      acc_d = acc_q;
      if (clr_i) begin
         acc_d = '0;
      end else if (en_i) begin
         acc_d = (first_i ? '0 : acc_q) + prod;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         acc_q <= '0;
      end else begin
         acc_q <= acc_d;
      end
   end

   assign acc_red_o = reduce(acc_q);
`ifdef MAT_MUL_SAT_EN
   assign ovf_o = EXT_W'(acc_q) > EXT_W'({OUT_WIDTH{1'b1}});
`endif

endmodule

// File: rtl/mat_mul_seq.sv
// Sequential C = A x B using one shared MAC, one product term per cycle.
// MAT_MUL_SAT_EN switches C elements from truncation to saturation.
module mat_mul_seq
   import mat_mul_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned OUT_WIDTH  = 8,
   parameter int unsigned ROWS_A     = 2,
   parameter int unsigned COLS_A     = 2,
   parameter int unsigned COLS_B     = 2
) (
   input  logic                                  clk,
   input  logic                                  rst,
   input  logic [ROWS_A*COLS_A*DATA_WIDTH-1:0]   a,
   input  logic [COLS_A*COLS_B*DATA_WIDTH-1:0]   b,
   input  logic                                  in_valid,
   output logic                                  in_ready,
   output logic [ROWS_A*COLS_B*OUT_WIDTH-1:0]    c,
   output logic                                  out_valid,
   input  logic                                  out_ready,
   output logic [COUNTER_W-1:0]                  counter
);

   localparam int unsigned NA    = ROWS_A * COLS_A;
   localparam int unsigned NB    = COLS_A * COLS_B;
   localparam int unsigned NC    = ROWS_A * COLS_B;
   localparam int unsigned ACC_W = acc_width(DATA_WIDTH, COLS_A);
   localparam int unsigned IW    = (ROWS_A > 1) ? $clog2(ROWS_A) : 1;
   localparam int unsigned JW    = (COLS_B > 1) ? $clog2(COLS_B) : 1;
   localparam int unsigned KW    = (COLS_A > 1) ? $clog2(COLS_A) : 1;
   localparam int unsigned CW    = (NC > 1) ? $clog2(NC) : 1;

   state_e                        state_q, state_d;
   logic [NA*DATA_WIDTH-1:0]      a_q, a_d;
   logic [NB*DATA_WIDTH-1:0]      b_q, b_d;
   logic [IW-1:0]                 i_q, i_d;
   logic [JW-1:0]                 j_q, j_d;
   logic [KW-1:0]                 k_q, k_d;
   logic                          wr_vld_q, wr_vld_d;
   logic [CW-1:0]                 wr_idx_q, wr_idx_d;
   logic [NC*OUT_WIDTH-1:0]       res_q, res_d;
   logic [NC*OUT_WIDTH-1:0]       c_q, c_d;
   logic [COUNTER_W-1:0]          cyc_q, cyc_d, cyc_inc;
   logic [COUNTER_W-1:0]          counter_q, counter_d;

   logic                          mac_clr, mac_en, mac_first;
   logic [OUT_WIDTH-1:0]          acc_red;
   logic [DATA_WIDTH-1:0]         a_elem, b_elem;
   int unsigned                   a_e, b_e, wr_e;
   logic                          last_i, last_j, last_k, last_wr;

`ifdef MAT_MUL_SAT_EN
   logic                          mac_ovf;
   logic                          sat_seen_q, sat_seen_d;
`endif

   assign a_e    = NA - 1 - elem_idx(32'(i_q), 32'(k_q), COLS_A);
   assign b_e    = NB - 1 - elem_idx(32'(k_q), 32'(j_q), COLS_B);
   assign wr_e   = NC - 1 - 32'(wr_idx_q);
   assign a_elem = a_q[a_e*DATA_WIDTH +: DATA_WIDTH];
   assign b_elem = b_q[b_e*DATA_WIDTH +: DATA_WIDTH];

   assign last_i  = (i_q == IW'(ROWS_A - 1));
   assign last_j  = (j_q == JW'(COLS_B - 1));
   assign last_k  = (k_q == KW'(COLS_A - 1));
   assign last_wr = wr_vld_q && (wr_idx_q == CW'(NC - 1));
   assign cyc_inc = (cyc_q == '1) ? cyc_q : cyc_q + 32'd1;

   mat_mul_mac #(
      .DATA_WIDTH (DATA_WIDTH),
      .ACC_W      (ACC_W),
      .OUT_WIDTH  (OUT_WIDTH)
   ) u_mac (
      .clk       (clk),
      .rst       (rst),
      .clr_i     (mac_clr),
      .en_i      (mac_en),
      .first_i   (mac_first),
      .a_i       (a_elem),
      .b_i       (b_elem),
`ifdef MAT_MUL_SAT_EN
      .ovf_o     (mac_ovf),
`endif
      .acc_red_o (acc_red)
   );

   always_comb begin
      state_d   = state_q;
      a_d       = a_q;
      b_d       = b_q;
      i_d       = i_q;
      j_d       = j_q;
      k_d       = k_q;
      wr_vld_d  = 1'b0;
      wr_idx_d  = wr_idx_q;
      res_d     = res_q;
      c_d       = c_q;
      cyc_d     = cyc_q;
      counter_d = counter_q;
      mac_clr   = 1'b0;
      mac_en    = 1'b0;
      mac_first = 1'b0;
`ifdef MAT_MUL_SAT_EN
      sat_seen_d = sat_seen_q;
      if (wr_vld_q && mac_ovf) begin
         sat_seen_d = 1'b1;
      end
`endif

      // The accumulator holds a finished sum for exactly one cycle after its last term.
      if (wr_vld_q) begin
         res_d[wr_e*OUT_WIDTH +: OUT_WIDTH] = acc_red;
      end

      unique case (state_q)
         StIdle: begin
            if (in_valid) begin
               a_d     = a;
               b_d     = b;
               i_d     = '0;
               j_d     = '0;
               k_d     = '0;
               cyc_d   = '0;
               mac_clr = 1'b1;
               state_d = StCompute;
`ifdef MAT_MUL_SAT_EN
               sat_seen_d = 1'b0;
`endif
            end
         end
         StCompute: begin
            cyc_d = cyc_inc;
            if (last_wr) begin
               c_d       = res_d;
               counter_d = cyc_inc;
               state_d   = StDone;
            end else begin
               mac_en    = 1'b1;
               mac_first = (k_q == '0);
               if (last_k) begin
                  wr_vld_d = 1'b1;
                  wr_idx_d = CW'(elem_idx(32'(i_q), 32'(j_q), COLS_B));
                  k_d      = '0;
                  if (last_j) begin
                     j_d = '0;
                     i_d = last_i ? '0 : i_q + IW'(1);
                  end else begin
                     j_d = j_q + JW'(1);
                  end
               end else begin
                  k_d = k_q + KW'(1);
               end
            end
         end
         StDone: begin
            if (out_ready) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= StIdle;
         a_q       <= '0;
         b_q       <= '0;
         i_q       <= '0;
         j_q       <= '0;
         k_q       <= '0;
         wr_vld_q  <= 1'b0;
         wr_idx_q  <= '0;
         res_q     <= '0;
         c_q       <= '0;
         cyc_q     <= '0;
         counter_q <= '0;
`ifdef MAT_MUL_SAT_EN
         sat_seen_q <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         a_q       <= a_d;
         b_q       <= b_d;
         i_q       <= i_d;
         j_q       <= j_d;
         k_q       <= k_d;
         wr_vld_q  <= wr_vld_d;
         wr_idx_q  <= wr_idx_d;
         res_q     <= res_d;
         c_q       <= c_d;
         cyc_q     <= cyc_d;
         counter_q <= counter_d;
`ifdef MAT_MUL_SAT_EN
         sat_seen_q <= sat_seen_d;
`endif
      end
   end

   assign in_ready  = (state_q == StIdle);
   assign out_valid = (state_q == StDone);
   assign c         = c_q;
   assign counter   = counter_q;

endmodule

// File: doc/mat_mul_seq.md
Name: mat_mul_seq

Overview:
- Parametrised, sequential successor to the team's fixed-size matrix multiplier.
- Computes C = A x B for ROWS_A x COLS_A by COLS_A x COLS_B unsigned matrices using one shared MAC unit, one product term per cycle.
- Valid/ready handshakes on both the operand side and the result side, plus a latency counter for performance checks.
- Sits between the operand register bank and the result consumer; it replaces the fixed 2x2 wrapper.

Parameters:
DATA_WIDTH, 8, width of each A/B element (unsigned)
OUT_WIDTH, 8, width of each C element as presented on c
ROWS_A, 2, rows of A and C (>=1)
COLS_A, 2, cols of A = rows of B, the inner dimension (>=1)
COLS_B, 2, cols of B and C (>=1)

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous reset, active-high
a  in  ROWS_A*COLS_A*DATA_WIDTH  matrix A, row-major, element 0 in MSBs
b  in  COLS_A*COLS_B*DATA_WIDTH  matrix B, row-major, element 0 in MSBs
in_valid  in  1  a/b valid
in_ready  out  1  block can accept operands
c  out  ROWS_A*COLS_B*OUT_WIDTH  result C, row-major, element 0 in MSBs
out_valid  out  1  c valid
out_ready  in  1  consumer accepts c
counter  out  32  cycles from accept to out_valid for the last job

Behaviour:
- Packing: element e = r*COLS + col occupies bits [(N-1-e)*W +: W].
- Reset is synchronous and active-high; while rst is high at a clk edge the block enters IDLE and clears all registers. Reset values: in_ready=1 (once in IDLE), out_valid=0, c=0, counter=0. Reset mid-COMPUTE or mid-DONE abandons the job; no partial result is ever presented.
- States:
  - IDLE: in_ready=1. On in_valid&&in_ready, copy a and b into internal registers, clear the accumulator and i/j/k indices, go to COMPUTE.
  - COMPUTE: in_ready=0. Each cycle acc += A[i][k]*B[k][j]. When k==COLS_A-1, write the final sum to C[i][j], clear acc, and advance j, then i (row-major). After the last (i,j,k), go to DONE.
  - DONE: out_valid=1 and c is stable. On out_ready, go to IDLE. in_ready stays 0 during the handshake cycle, so there is no same-cycle re-accept.
- Latency: out_valid rises exactly ROWS_A*COLS_A*COLS_B+1 clk edges after the accept edge. counter loads that value on DONE entry and holds until the next DONE entry. The internal cycle count saturates at 2^32-1.
- Operands are captured at accept; later changes to a/b have no effect on the running job.
- c keeps the last result after out_ready, until it is overwritten at the next DONE entry.
- out_ready while out_valid=0 is ignored. in_valid outside IDLE is ignored, not queued.
- Arithmetic is unsigned. Accumulator width ACC_W = 2*DATA_WIDTH + clog2(COLS_A) + 1, so the accumulator never overflows.
- The reduction to OUT_WIDTH happens only at the C write. The default reduction is truncation to the low OUT_WIDTH bits (modulo wrap).
- Degenerate dimensions (1x1x1) must work. Latency is then 2 edges.

Optional Feature:
- Macro MAT_MUL_SAT_EN.
- Defined: each C element saturates to 2^OUT_WIDTH-1 when the accumulator exceeds it. An internal sticky flag sat_seen is set for the job and cleared on accept.
- Undefined: each C element is the truncated low OUT_WIDTH bits and no flag logic exists.
- Ports are identical in both builds.

Decomposition:
- Package mat_mul_pkg:
  - state enum (IDLE, COMPUTE, DONE)
  - function acc_width(DATA_WIDTH, COLS_A)
  - function elem_idx(row, col, cols)
  - COUNTER_W=32 constant
- Sub-module mat_mul_mac:
  - registered multiply-accumulate with clear and enable, parametrised DATA_WIDTH/ACC_W
  - also contains the reduce-to-OUT_WIDTH function (truncate or saturate under the macro)

Test Plan:
- Defaults. A={2,4,6,7}, B={1,4,7,9}, pulse in_valid, out_ready=1 -> out_valid 9 cycles after accept, c={30,44,55,87}, counter=9.
- Backpressure. Same job with out_ready=0 for 20 cycles -> out_valid and c hold steady and in_ready=0 throughout. Raise out_ready -> out_valid falls next cycle, in_ready rises.
- Overflow. All elements 255, DATA_WIDTH=OUT_WIDTH=8 -> every c element = 2 without MAT_MUL_SAT_EN, 255 with it.
- Reset mid-job. Assert rst for 1 cycle at cycle 4 of COMPUTE -> out_valid=0, c=0, in_ready=1. The next job {1,0,0,1}x{5,6,7,8} yields {5,6,7,8}.
- Non-square. ROWS_A=2, COLS_A=3, COLS_B=1, OUT_WIDTH=16, A={1,2,3,4,5,6}, B={1,1,1} -> c={6,15}, counter=7. A 1x1x1 build with 3*5 -> c=15, counter=2.
- Operand hold. Change a/b during COMPUTE -> result matches the captured operands. in_valid held high through DONE -> exactly one job accepted per IDLE visit.
